// File: rtl/polygon_vertex_buffer_pkg.sv
// Shared types for the polygon vertex buffer: vertex record, bank depth and FSM states.
package polygon_pkg;

    localparam int DEFAULT_MAX_NUM_VERTICES = 32;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } vertex_t;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        DROP    = 2'd1,
        PENDING = 2'd2
    } buf_state_t;

endpackage

// File: rtl/polygon_vertex_buffer_if.sv
// Vertex write stream: one world-space vertex per beat, valid/ready handshake, last marks polygon end.
interface polygon_vertex_buffer_if;

    logic               wr_valid_in;
    logic               wr_ready_out;
    logic signed [31:0] wr_x_in;
    logic signed [31:0] wr_y_in;
    logic               wr_last_in;

    modport master (
        output wr_valid_in, wr_x_in, wr_y_in, wr_last_in,
        input  wr_ready_out
    );

    modport slave (
        input  wr_valid_in, wr_x_in, wr_y_in, wr_last_in,
        output wr_ready_out
    );

endinterface

// File: rtl/polygon_vertex_buffer_bank.sv
// One vertex bank: single write port, every entry visible in parallel.
module vertex_bank
    import polygon_pkg::*;
#(
    parameter  int MAX_NUM_VERTICES = DEFAULT_MAX_NUM_VERTICES,
    localparam int AW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic signed [31:0] wr_x,
    input  logic signed [31:0] wr_y,
    output logic signed [31:0] xs [MAX_NUM_VERTICES],
    output logic signed [31:0] ys [MAX_NUM_VERTICES]
);

    vertex_t mem [MAX_NUM_VERTICES];

    // Storage: cleared on reset, one entry written per enabled cycle.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= vertex_t'{x: wr_x, y: wr_y};
        end
    end

    // Full parallel read-out split into coordinate arrays.
    always_comb begin
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            xs[i] = mem[i].x;
            ys[i] = mem[i].y;
        end
    end

endmodule

// File: rtl/polygon_vertex_buffer.sv
// Double-buffered polygon vertex store: loads the back bank from a vertex stream,
// validates the count and swaps banks at the frame strobe.
module polygon_vertex_buffer
    import polygon_pkg::*;
#(
    parameter int MAX_NUM_VERTICES = DEFAULT_MAX_NUM_VERTICES
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    polygon_vertex_buffer_if.slave                   wr,
    input  logic                                     frame_start_in,
    output logic signed [31:0]                       xs_out [MAX_NUM_VERTICES],
    output logic signed [31:0]                       ys_out [MAX_NUM_VERTICES],
    output logic [$clog2(MAX_NUM_VERTICES+1)-1:0]    num_points_out,
    output logic                                     poly_valid_out,
    output logic                                     err_out
);

    localparam int PW = $clog2(MAX_NUM_VERTICES + 1);
    localparam int AW = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1;
    localparam logic [PW-1:0] PTR_FULL     = PW'(MAX_NUM_VERTICES);
    localparam logic [PW-1:0] PTR_TOO_FEW  = PW'(2);

    buf_state_t         state;
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      back_count;
    logic               front_sel;
    logic               ready;
    logic               accept;
    logic               bank_we;
    logic signed [31:0] a_xs [MAX_NUM_VERTICES];
    logic signed [31:0] a_ys [MAX_NUM_VERTICES];
    logic signed [31:0] b_xs [MAX_NUM_VERTICES];
    logic signed [31:0] b_ys [MAX_NUM_VERTICES];

    assign ready           = (state != PENDING);
    assign wr.wr_ready_out = ready;
    assign accept          = wr.wr_valid_in && ready;
    // A full bank swallows no further vertices; the overflow beat itself is not stored.
    assign bank_we         = accept && (state == LOAD) && (wr_ptr != PTR_FULL);

    // Bank A is front while front_sel = 0, so it only takes writes when front_sel = 1.
    vertex_bank #(.MAX_NUM_VERTICES(MAX_NUM_VERTICES)) u_bank_a (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (bank_we & front_sel),
        .addr   (wr_ptr[AW-1:0]),
        .wr_x   (wr.wr_x_in),
        .wr_y   (wr.wr_y_in),
        .xs     (a_xs),
        .ys     (a_ys)
    );

    vertex_bank #(.MAX_NUM_VERTICES(MAX_NUM_VERTICES)) u_bank_b (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .we     (bank_we & ~front_sel),
        .addr   (wr_ptr[AW-1:0]),
        .wr_x   (wr.wr_x_in),
        .wr_y   (wr.wr_y_in),
        .xs     (b_xs),
        .ys     (b_ys)
    );

    // Publish whichever bank is front.
    always_comb begin
        for (int i = 0; i < MAX_NUM_VERTICES; i++) begin
            xs_out[i] = front_sel ? b_xs[i] : a_xs[i];
            ys_out[i] = front_sel ? b_ys[i] : a_ys[i];
        end
    end

    // Load/validate/swap sequencing with registered status outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state          <= LOAD;
            wr_ptr         <= '0;
            back_count     <= '0;
            front_sel      <= 1'b0;
            num_points_out <= '0;
            poly_valid_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            err_out <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (wr.wr_last_in) begin
                            if (wr_ptr == PTR_FULL || wr_ptr < PTR_TOO_FEW) begin
                                // Count would be below 3 or above capacity: discard.
                                err_out <= 1'b1;
                                wr_ptr  <= '0;
                            end else begin
                                back_count <= wr_ptr + PW'(1);
                                state      <= PENDING;
                            end
                        end else if (wr_ptr == PTR_FULL) begin
                            err_out <= 1'b1;
                            state   <= DROP;
                        end else begin
                            wr_ptr <= wr_ptr + PW'(1);
                        end
                    end
                end
                DROP: begin
                    if (accept && wr.wr_last_in) begin
                        wr_ptr <= '0;
                        state  <= LOAD;
                    end
                end
                PENDING: begin
                    if (frame_start_in) begin
                        front_sel      <= ~front_sel;
                        num_points_out <= back_count;
                        poly_valid_out <= 1'b1;
                        wr_ptr         <= '0;
                        state          <= LOAD;
                    end
                end
                default: begin
                    state  <= LOAD;
                    wr_ptr <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_polygon_vertex_buffer.sv
// Bench for polygon_vertex_buffer: directed scenarios plus a randomized run against a list-level model.
module tb_polygon_vertex_buffer;

    localparam int MAX = 32;
    localparam int NW  = $clog2(MAX + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               frame_start;
    logic signed [31:0] xs [MAX];
    logic signed [31:0] ys [MAX];
    logic [NW-1:0]      num_points;
    logic               poly_valid;
    logic               err;

    polygon_vertex_buffer_if vif ();

    polygon_vertex_buffer #(.MAX_NUM_VERTICES(MAX)) dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .wr             (vif),
        .frame_start_in (frame_start),
        .xs_out         (xs),
        .ys_out         (ys),
        .num_points_out (num_points),
        .poly_valid_out (poly_valid),
        .err_out        (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: polygons as vertex lists.
    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } pt_t;

    pt_t                cur_q[$];
    pt_t                pend_q[$];
    bit                 have_pend;
    bit                 dropping;
    bit                 m_valid;
    bit                 m_err;
    int                 pub_n;
    logic signed [31:0] pub_x [MAX];
    logic signed [31:0] pub_y [MAX];

    task automatic model_reset();
        cur_q.delete();
        pend_q.delete();
        have_pend = 0;
        dropping  = 0;
        m_valid   = 0;
        m_err     = 0;
        pub_n     = 0;
        for (int i = 0; i < MAX; i++) begin
            pub_x[i] = 0;
            pub_y[i] = 0;
        end
    endtask

    // Applies one clock edge worth of spec behaviour to the model.
    task automatic model_step();
        pt_t p;
        int  n;
        m_err = 0;
        if (!rst_n) begin
            model_reset();
        end else if (have_pend) begin
            if (frame_start) begin
                for (int i = 0; i < pend_q.size(); i++) begin
                    pub_x[i] = pend_q[i].x;
                    pub_y[i] = pend_q[i].y;
                end
                pub_n     = pend_q.size();
                m_valid   = 1;
                have_pend = 0;
                pend_q.delete();
            end
        end else if (vif.wr_valid_in) begin
            p.x = vif.wr_x_in;
            p.y = vif.wr_y_in;
            if (dropping) begin
                if (vif.wr_last_in) dropping = 0;
            end else if (vif.wr_last_in) begin
                n = cur_q.size() + 1;
                if (n >= 3 && n <= MAX) begin
                    pend_q = cur_q;
                    pend_q.push_back(p);
                    have_pend = 1;
                end else begin
                    m_err = 1;
                end
                cur_q.delete();
            end else if (cur_q.size() == MAX) begin
                m_err    = 1;
                dropping = 1;
                cur_q.delete();
            end else begin
                cur_q.push_back(p);
            end
        end
    endtask

    task automatic drive_cycle(input bit v, input logic signed [31:0] x, input logic signed [31:0] y,
                               input bit last, input bit fs);
        vif.wr_valid_in = v;
        vif.wr_x_in     = x;
        vif.wr_y_in     = y;
        vif.wr_last_in  = last;
        frame_start     = fs;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        checks++;
        if (vif.wr_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", vif.wr_ready_out); end
        checks++;
        if (poly_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", poly_valid); end
        checks++;
        if (num_points !== '0) begin errors++; $display("FAIL reset_num got %0d exp 0", num_points); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        bad = 0;
        for (int i = 0; i < MAX; i++) if (xs[i] !== 0 || ys[i] !== 0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL reset_arrays nonzero entries got %0d exp 0", bad); end
    endtask

    task automatic test_triangle();
        logic signed [31:0] ex [3];
        logic signed [31:0] ey [3];
        ex[0] = 0; ex[1] = 10; ex[2] = 0;
        ey[0] = 0; ey[1] = 0;  ey[2] = 10;
        drive_cycle(1, 0, 0, 0, 0);
        drive_cycle(1, 10, 0, 0, 0);
        drive_cycle(1, 0, 10, 1, 0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL tri_err got %b exp 0", err); end
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1, 77, 77, 0, 0);
            checks++;
            if (vif.wr_ready_out !== 1'b0) begin errors++; $display("FAIL tri_backpressure cycle %0d got %b exp 0", k, vif.wr_ready_out); end
        end
        checks++;
        if (poly_valid !== 1'b0) begin errors++; $display("FAIL tri_early_valid got %b exp 0", poly_valid); end
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (poly_valid !== 1'b1 || num_points !== NW'(3)) begin
            errors++; $display("FAIL tri_publish valid %b num %0d exp 1 3", poly_valid, num_points);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (xs[i] !== ex[i] || ys[i] !== ey[i]) begin
                errors++; $display("FAIL tri_vertex%0d got (%0d,%0d) exp (%0d,%0d)", i, xs[i], ys[i], ex[i], ey[i]);
            end
        end
        checks++;
        if (vif.wr_ready_out !== 1'b1) begin errors++; $display("FAIL tri_ready_after_swap got %b exp 1", vif.wr_ready_out); end
    endtask

    task automatic test_square();
        logic signed [31:0] sx [4];
        logic signed [31:0] sy [4];
        sx[0] = 0; sx[1] = 20; sx[2] = 20; sx[3] = 0;
        sy[0] = 0; sy[1] = 0;  sy[2] = 20; sy[3] = 20;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1, sx[i], sy[i], i == 3, 0);
            checks++;
            if (num_points !== NW'(3) || xs[1] !== 10 || ys[2] !== 10) begin
                errors++; $display("FAIL sq_disturb beat %0d num %0d xs1 %0d ys2 %0d exp 3 10 10", i, num_points, xs[1], ys[2]);
            end
        end
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (num_points !== NW'(4)) begin errors++; $display("FAIL sq_num got %0d exp 4", num_points); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (xs[i] !== sx[i] || ys[i] !== sy[i]) begin
                errors++; $display("FAIL sq_vertex%0d got (%0d,%0d) exp (%0d,%0d)", i, xs[i], ys[i], sx[i], sy[i]);
            end
        end
    endtask

    task automatic test_short();
        int pulses;
        pulses = 0;
        drive_cycle(1, 5, 5, 0, 0);
        pulses += int'(err);
        drive_cycle(1, 6, 6, 1, 0);
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL short_err_edge got %b exp 1", err); end
        pulses += int'(err);
        for (int k = 0; k < 3; k++) begin
            drive_cycle(0, 0, 0, 0, (k == 1));
            pulses += int'(err);
            checks++;
            if (vif.wr_ready_out !== 1'b1) begin errors++; $display("FAIL short_ready got %b exp 1", vif.wr_ready_out); end
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL short_pulses got %0d exp 1", pulses); end
        checks++;
        if (num_points !== NW'(4) || xs[1] !== 20) begin errors++; $display("FAIL short_published num %0d xs1 %0d exp 4 20", num_points, xs[1]); end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 34; k++) begin
            drive_cycle(1, $urandom, $urandom, k == 34, 0);
            checks++;
            if (err !== (k == 33)) begin errors++; $display("FAIL ovf_err beat %0d got %b exp %b", k, err, (k == 33)); end
            checks++;
            if (vif.wr_ready_out !== 1'b1) begin errors++; $display("FAIL ovf_ready beat %0d got %b exp 1", k, vif.wr_ready_out); end
        end
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (num_points !== NW'(4) || xs[2] !== 20 || poly_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_published num %0d xs2 %0d valid %b exp 4 20 1", num_points, xs[2], poly_valid);
        end
    endtask

    task automatic test_coincident();
        drive_cycle(1, 100, 1, 0, 0);
        drive_cycle(1, 200, 2, 0, 0);
        drive_cycle(1, 300, 3, 1, 1);
        checks++;
        if (num_points !== NW'(4) || vif.wr_ready_out !== 1'b0) begin
            errors++; $display("FAIL coinc_noswap num %0d ready %b exp 4 0", num_points, vif.wr_ready_out);
        end
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (num_points !== NW'(3) || xs[0] !== 100 || xs[2] !== 300 || ys[1] !== 2) begin
            errors++; $display("FAIL coinc_swap num %0d xs0 %0d xs2 %0d ys1 %0d exp 3 100 300 2", num_points, xs[0], xs[2], ys[1]);
        end
    endtask

    task automatic test_midstream_reset();
        int bad;
        for (int k = 0; k < 5; k++) drive_cycle(1, 40 + k, 50 + k, 0, 0);
        rst_n = 1'b0;
        drive_cycle(1, 9, 9, 0, 0);
        rst_n = 1'b1;
        checks++;
        if (poly_valid !== 1'b0 || num_points !== '0 || err !== 1'b0 || vif.wr_ready_out !== 1'b1) begin
            errors++; $display("FAIL mrst_outputs valid %b num %0d err %b ready %b exp 0 0 0 1", poly_valid, num_points, err, vif.wr_ready_out);
        end
        bad = 0;
        for (int i = 0; i < MAX; i++) if (xs[i] !== 0 || ys[i] !== 0) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mrst_arrays nonzero entries got %0d exp 0", bad); end
        drive_cycle(1, -3, 7, 0, 0);
        drive_cycle(1, 8, -9, 0, 0);
        drive_cycle(1, 11, 12, 1, 0);
        drive_cycle(0, 0, 0, 0, 1);
        checks++;
        if (poly_valid !== 1'b1 || num_points !== NW'(3) || xs[0] !== -3 || ys[1] !== -9 || xs[2] !== 11) begin
            errors++; $display("FAIL mrst_tri valid %b num %0d xs0 %0d ys1 %0d xs2 %0d exp 1 3 -3 -9 11",
                               poly_valid, num_points, xs[0], ys[1], xs[2]);
        end
    endtask

    task automatic test_random();
        int mism;
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 599) != 0);
            drive_cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
            checks++;
            if (vif.wr_ready_out !== !have_pend) begin errors++; $display("FAIL rnd_ready cycle %0d got %b exp %b", c, vif.wr_ready_out, !have_pend); end
            checks++;
            if (err !== m_err) begin errors++; $display("FAIL rnd_err cycle %0d got %b exp %b", c, err, m_err); end
            checks++;
            if (poly_valid !== m_valid || num_points !== NW'(pub_n)) begin
                errors++; $display("FAIL rnd_status cycle %0d valid %b num %0d exp %b %0d", c, poly_valid, num_points, m_valid, pub_n);
            end
            mism = 0;
            for (int i = 0; i < pub_n; i++) if (xs[i] !== pub_x[i] || ys[i] !== pub_y[i]) mism++;
            checks++;
            if (mism != 0) begin errors++; $display("FAIL rnd_vertices cycle %0d mismatched entries %0d exp 0", c, mism); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        frame_start     = 1'b0;
        vif.wr_valid_in = 1'b0;
        vif.wr_x_in     = '0;
        vif.wr_y_in     = '0;
        vif.wr_last_in  = 1'b0;
        model_reset();
        test_reset();
        test_triangle();
        test_square();
        test_short();
        test_overflow();
        test_coincident();
        test_midstream_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/polygon_vertex_buffer.md
# polygon_vertex_buffer

Double-buffered vertex store directly upstream of the polygon renderer. It accepts one polygon as a serial stream of world-space vertices over a valid/ready handshake and validates the vertex count. At each frame boundary it publishes the completed polygon as parallel vertex arrays and a count, so the renderer never sees a half-written polygon mid-frame.

## Interface
Parameters
- MAX_NUM_VERTICES, 32: capacity of each bank; the renderer's vertex-array size.

Ports
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  reset, synchronous, active-low.
- wr_valid_in  input  1  write beat valid.
- wr_ready_out  output  1  buffer can accept a beat.
- wr_x_in  input  signed 32  vertex world x.
- wr_y_in  input  signed 32  vertex world y.
- wr_last_in  input  1  beat is the final vertex of the polygon.
- frame_start_in  input  1  one-cycle strobe at the start of the display frame; swap point.
- xs_out  output  signed 32 × MAX_NUM_VERTICES  published x coordinates, in input order.
- ys_out  output  signed 32 × MAX_NUM_VERTICES  published y coordinates.
- num_points_out  output  $clog2(MAX_NUM_VERTICES+1)  published vertex count (3..MAX).
- poly_valid_out  output  1  a published polygon exists.
- err_out  output  1  one-cycle pulse when a polygon is discarded.

## Operation
- Two banks, A and B. A front-select register (front_sel) marks the published bank. The other bank is the back bank.
- A beat is accepted when wr_valid_in && wr_ready_out.
- States:
  - LOAD: each accepted beat writes back[wr_ptr] and increments wr_ptr.
    - On a last beat with final count (wr_ptr+1) in 3..MAX: latch back_count and go to PENDING.
    - On a last beat with count < 3: discard the polygon, pulse err_out, reset wr_ptr to 0, stay in LOAD.
    - On a non-last beat when wr_ptr == MAX: do not write, pulse err_out, go to DROP.
  - DROP: accept and ignore beats until a last beat, then go to LOAD with wr_ptr = 0. err_out does not pulse again.
  - PENDING: wr_ready_out = 0. On frame_start_in: toggle front_sel, num_points_out ← back_count, poly_valid_out ← 1, wr_ptr ← 0, go to LOAD.
- frame_start_in in LOAD or DROP: no change. The old polygon stays published.
- A last beat accepted in the same cycle as frame_start_in is not swapped that frame. The FSM enters PENDING and swaps at the next strobe.
- wr_ready_out = (state != PENDING), decoded from the state register.
- Outputs drive the front bank through a mux on front_sel. Entries at or beyond num_points_out hold stale data; consumers use only num_points_out entries.
- Reset mid-stream: the partial polygon is lost, poly_valid_out = 0, and the FSM returns to LOAD.

## Timing
- Reset values: state LOAD, wr_ptr 0, front_sel 0, both banks 0, num_points_out 0, poly_valid_out 0, err_out 0, wr_ready_out 1.
- Write throughput: one vertex per cycle in LOAD and DROP.
- Swap latency: frame_start_in sampled in PENDING at cycle N. xs_out, ys_out, num_points_out and poly_valid_out reflect the new polygon from cycle N+1. wr_ready_out rises at N+1.
- err_out is high in the cycle after the offending beat is accepted, for exactly one cycle.
- The back bank is never written in PENDING. The front bank is never written.

## Structure
- Package polygon_pkg:
  - typedef vertex_t (signed 32 x, signed 32 y)
  - localparam DEFAULT_MAX_NUM_VERTICES = 32
  - enum buf_state_t {LOAD, DROP, PENDING}
- One sub-module, vertex_bank:
  - MAX_NUM_VERTICES-entry register array
  - single write port (we, addr, x, y)
  - full parallel read-out
  - instantiated twice, with write enable gated by ~front_sel / front_sel.

## Test plan
- Reset, then stream a triangle (0,0),(10,0),(0,10) with last on the third beat, then pulse frame_start_in → next cycle poly_valid_out=1, num_points_out=3, xs_out[0..2]=0,10,0, ys_out[0..2]=0,0,10.
- After the triangle is pending, hold wr_valid_in high → wr_ready_out=0 until frame_start_in. Then a new 4-vertex square loads without disturbing the published triangle until the next strobe.
- Stream 2 vertices with last → err_out pulses once, nothing published, wr_ready_out stays 1.
- Stream 34 vertices, last on the 34th, with MAX=32 → err_out pulses once at beat 33, FSM returns to LOAD after beat 34, published polygon unchanged.
- Last beat coincident with frame_start_in → no swap that cycle. The swap occurs at the following frame_start_in.
- Assert rst_in low mid-stream after 5 beats → all outputs return to reset values. A following triangle loads and publishes correctly.
